multicycle_ctrl: RTL and testbench

Multi-cycle control unit that sequences the existing fetch/decode/execute/memory/writeback datapath (yIF, yID, yEX, yDM, yWB). It replaces per-instruction control decoding done in benches. It steps each instruction through FETCH→DECODE→EXEC→MEM→WB as needed, drives all datapath control strobes, and owns the PC update decision. It retires one instruction per pass and halts permanently on an illegal opcode.

---
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the yIF/yID/yEX/yDM/yWB datapath.
// Sequences FETCH->DECODE->EXEC->MEM->WB per instruction; halts on illegal opcodes.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic [2:0]       op,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;

  state_t     st, nx;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b5;

  logic is_r, is_i, is_lw, is_sw, is_beq, is_jal;
  logic r_ok, legal, exec_src;
  logic [2:0] rop, exec_op;

  // Only opcode/funct3/f7b5 steer control; the rest of ins is datapath-only.
  logic unused_ins;
  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  assign is_r   = (opc == 7'h33);
  assign is_i   = (opc == 7'h13);
  assign is_lw  = (opc == 7'h03);
  assign is_sw  = (opc == 7'h23);
  assign is_beq = (opc == 7'h63);
  assign is_jal = (opc == 7'h6F);

  assign r_ok  = (f3 == 3'd0) || (f3 == 3'd6) || (f3 == 3'd7);
  assign legal = (is_r && r_ok) || is_i || is_lw || is_sw || is_beq || is_jal;

  always_comb begin
    rop = OP_ADD;
    case (f3)
      3'd7:    rop = OP_AND;
      3'd6:    rop = OP_OR;
      default: rop = f7b5 ? OP_SUB : OP_ADD;
    endcase
  end

  assign exec_op  = is_beq ? OP_SUB : (is_r ? rop : OP_ADD);
  assign exec_src = !(is_r || is_beq);

  assign state = st;

  always_comb begin
    nx       = st;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 2'b00;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    op       = OP_AND;
    halted   = 1'b0;
    case (st)
      FETCH: begin
        ir_write = run && rst_n;
        nx       = run ? DECODE : FETCH;
      end
      DECODE: nx = legal ? EXEC : HALT;
      EXEC: begin
        ALUSrc = exec_src;
        op     = exec_op;
        unique case (1'b1)
          is_beq: begin
            pc_write = 1'b1;
            pc_sel   = zero ? 2'b01 : 2'b00;
            nx       = FETCH;
          end
          is_jal: begin
            pc_write = 1'b1;
            pc_sel   = 2'b10;
            nx       = FETCH;
          end
          is_lw, is_sw: nx = MEM;
          default:      nx = WB;
        endcase
      end
      MEM: begin
        ALUSrc = 1'b1;
        op     = OP_ADD;
        if (is_lw) begin
          MemRead = 1'b1;
          nx      = WB;
        end else begin
          MemWrite = 1'b1;
          pc_write = 1'b1;
          nx       = FETCH;
        end
      end
      WB: begin
        RegWrite = 1'b1;
        Mem2Reg  = is_lw;
        ALUSrc   = exec_src;
        op       = exec_op;
        pc_write = 1'b1;
        nx       = FETCH;
      end
      HALT: begin
        halted = 1'b1;
        nx     = HALT;
      end
      default: nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= FETCH;
      opc     <= '0;
      f3      <= '0;
      f7b5    <= 1'b0;
      retired <= '0;
    end else begin
      st <= nx;
      if (st == FETCH && run) begin
        opc  <= ins[6:0];
        f3   <= ins[14:12];
        f7b5 <= ins[30];
      end
      if (pc_write)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised + directed bench for multicycle_ctrl.
// Two DUTs share stimulus: CNT_W=16 (full check) and CNT_W=2 (counter wrap).
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] ins = '0;

  logic        a_irw, a_pcw, a_rw, a_src, a_mr, a_mw, a_m2r, a_h;
  logic [1:0]  a_sel;
  logic [2:0]  a_op, a_st;
  logic [15:0] a_ret;

  logic        b_irw, b_pcw, b_rw, b_src, b_mr, b_mw, b_m2r, b_h;
  logic [1:0]  b_sel;
  logic [2:0]  b_op, b_st;
  logic [1:0]  b_ret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .ins(ins), .zero(zero),
    .ir_write(a_irw), .pc_write(a_pcw), .pc_sel(a_sel),
    .RegWrite(a_rw), .ALUSrc(a_src), .MemRead(a_mr),
    .MemWrite(a_mw), .Mem2Reg(a_m2r), .op(a_op),
    .state(a_st), .halted(a_h), .retired(a_ret)
  );

  multicycle_ctrl #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .ins(ins), .zero(zero),
    .ir_write(b_irw), .pc_write(b_pcw), .pc_sel(b_sel),
    .RegWrite(b_rw), .ALUSrc(b_src), .MemRead(b_mr),
    .MemWrite(b_mw), .Mem2Reg(b_m2r), .op(b_op),
    .state(b_st), .halted(b_h), .retired(b_ret)
  );

  typedef struct {
    logic [2:0] st;
    logic       irw, pcw, rw, src, mr, mw, m2r, h;
    logic [1:0] sel;
    logic [2:0] op;
    bit         aluv;
  } exp_t;

  // Instruction classes: 0 R, 1 addi, 2 lw, 3 sw, 4 beq, 5 jal, 6 illegal.
  // step counts cycles since FETCH; the instruction ends on its pc_write.
  int         cls = -1;
  int         step = 0;
  bit         mhalt = 0;
  int         mret = 0;
  logic [2:0] mrop = 3'b010;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] seen[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, want);
    end
  endtask

  function automatic int classify(input logic [31:0] w,
                                  output logic [2:0] r);
    r = 3'b010;
    case (w[6:0])
      7'h33: begin
        case (w[14:12])
          3'd0: r = w[30] ? 3'b110 : 3'b010;
          3'd7: r = 3'b000;
          3'd6: r = 3'b001;
          default: return 6;
        endcase
        return 0;
      end
      7'h13: return 1;
      7'h03: return 2;
      7'h23: return 3;
      7'h63: return 4;
      7'h6F: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic       s;
    logic [2:0] o;
    e = '{default: '0};
    if (!rst_n) return e;
    if (mhalt) begin
      e.st = 3'd5;
      e.h  = 1'b1;
      return e;
    end
    if (cls < 0) begin
      e.irw = run;
      return e;
    end
    s = !(cls == 0 || cls == 4);
    o = (cls == 4) ? 3'b110 : ((cls == 0) ? mrop : 3'b010);
    case (step)
      1: e.st = 3'd1;
      2: begin
        e.st = 3'd2; e.aluv = 1; e.src = s; e.op = o;
        if (cls == 4 || cls == 5) begin
          e.pcw = 1'b1;
          e.sel = (cls == 5) ? 2'b10 : (zero ? 2'b01 : 2'b00);
        end
      end
      3: begin
        if (cls == 2 || cls == 3) begin
          e.st = 3'd3; e.aluv = 1; e.src = 1'b1; e.op = 3'b010;
          e.mr = (cls == 2);
          e.mw = (cls == 3);
          e.pcw = (cls == 3);
        end else begin
          e.st = 3'd4; e.aluv = 1; e.src = s; e.op = o;
          e.rw = 1'b1; e.pcw = 1'b1;
        end
      end
      default: begin
        e.st = 3'd4; e.aluv = 1; e.src = 1'b1; e.op = 3'b010;
        e.rw = 1'b1; e.m2r = 1'b1; e.pcw = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic advance(input exp_t e);
    if (!rst_n || mhalt) return;
    if (cls < 0) begin
      if (run) begin
        cls  = classify(ins, mrop);
        step = 1;
      end
    end else if (e.pcw) begin
      mret++;
      cls = -1;
    end else if (cls == 6) begin
      mhalt = 1;
      cls   = -1;
    end else begin
      step++;
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    @(negedge clk);
    e = expect_now();
    seen.push_back(a_st);
    chk("state",    32'(a_st),  32'(e.st));
    chk("ir_write", 32'(a_irw), 32'(e.irw));
    chk("pc_write", 32'(a_pcw), 32'(e.pcw));
    chk("pc_sel",   32'(a_sel), 32'(e.sel));
    chk("RegWrite", 32'(a_rw),  32'(e.rw));
    chk("MemRead",  32'(a_mr),  32'(e.mr));
    chk("MemWrite", 32'(a_mw),  32'(e.mw));
    chk("Mem2Reg",  32'(a_m2r), 32'(e.m2r));
    chk("halted",   32'(a_h),   32'(e.h));
    chk("retired",  32'(a_ret), 32'(mret[15:0]));
    chk("b_state",  32'(b_st),  32'(e.st));
    chk("b_retired", 32'(b_ret), 32'(mret[1:0]));
    if (e.aluv) begin
      chk("ALUSrc", 32'(a_src), 32'(e.src));
      chk("op",     32'(a_op),  32'(e.op));
    end
    @(posedge clk);
    advance(e);
    #1;
  endtask

  task automatic model_reset();
    cls = -1; step = 0; mhalt = 0; mret = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    check_cycle();
    rst_n = 1'b1;
  endtask

  task automatic instr(input logic [31:0] w, input int n);
    ins = w;
    seen.delete();
    repeat (n) check_cycle();
  endtask

  function automatic logic [14:0] trace5();
    logic [14:0] t;
    t = '0;
    foreach (seen[i]) if (i < 5) t = {t[11:0], seen[i]};
    return t;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 19);
    if (k < 5) begin
      w[6:0] = 7'h33;
      case ($urandom_range(0, 4))
        0, 1: w[14:12] = 3'd0;
        2:    w[14:12] = 3'd7;
        3:    w[14:12] = 3'd6;
        default: w[14:12] = 3'($urandom_range(1, 5));
      endcase
    end
    else if (k < 8)  w[6:0] = 7'h13;
    else if (k < 11) w[6:0] = 7'h03;
    else if (k < 14) w[6:0] = 7'h23;
    else if (k < 17) w[6:0] = 7'h63;
    else if (k < 19) w[6:0] = 7'h6F;
    return w;
  endfunction

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LW  = 32'h0000A283;
  localparam logic [31:0] SW  = 32'h0050A223;
  localparam logic [31:0] BEQ = 32'h00208463;
  localparam logic [31:0] JAL = 32'h0100006F;

  initial begin
    logic [7:0] wraps;
    run = 1'b1;
    do_reset();

    instr(ADD, 4);
    chk("add_trace", 32'(trace5()), 32'(12'o0124));
    chk("add_ret", 32'(a_ret), 32'd1);
    instr(LW, 5);
    chk("lw_trace", 32'(trace5()), 32'(15'o01234));
    instr(SW, 4);
    chk("sw_trace", 32'(trace5()), 32'(12'o0123));
    chk("sw_ret", 32'(a_ret), 32'd3);
    zero = 1'b1;
    instr(BEQ, 3);
    chk("beq1_trace", 32'(trace5()), 32'(9'o012));
    zero = 1'b0;
    instr(BEQ, 3);
    chk("beq0_trace", 32'(trace5()), 32'(9'o012));
    instr(JAL, 3);
    chk("jal_ret", 32'(a_ret), 32'd6);
    instr(32'hFFFFFFFF, 13);
    chk("halt_flag", 32'(a_h), 32'd1);
    chk("halt_ret", 32'(a_ret), 32'd6);

    do_reset();
    instr(ADD, 4);
    instr(LW, 3);
    chk("in_mem", 32'(a_st), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(a_st), 32'd0);
    chk("arst_memread", 32'(a_mr), 32'd0);
    chk("arst_ret", 32'(a_ret), 32'd0);
    model_reset();
    check_cycle();
    run = 1'b0;
    rst_n = 1'b1;
    instr(ADD, 5);
    chk("idle_state", 32'(a_st), 32'd0);
    run = 1'b1;

    do_reset();
    wraps = '0;
    for (int i = 0; i < 4; i++) begin
      instr(ADD, 4);
      wraps = {wraps[5:0], b_ret};
    end
    chk("wrap_seq", 32'(wraps), 32'(8'b01_10_11_00));
    instr(ADD, 4);
    chk("wrap_last", 32'(b_ret), 32'd1);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run  = ($urandom_range(0, 9) < 7);
      zero = 1'($urandom);
      ins  = gen();
      if ((mhalt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      else
        check_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
